// File: rtl/phase1_code_tx_if.sv
// Handshake and serial-line bundle between the vault controller and the Phase-1 code transmitter.
// The master side drives the request and ack inputs; the slave side is the transmitter.
interface phase1_code_tx_if #(
  parameter int unsigned CODE_WIDTH  = 4,
  parameter int unsigned MAX_RETRIES = 2
);
  localparam int unsigned ATT_W = $clog2(MAX_RETRIES + 2);

  logic                  start;
  logic [CODE_WIDTH-1:0] code_word;
  logic                  abort;
  logic                  ack_in;
  logic                  code_out;
  logic                  ready;
  logic                  busy;
  logic                  tx_ok;
  logic                  tx_fail;
  logic [ATT_W-1:0]      attempt;

  modport master (
    output start, code_word, abort, ack_in,
    input  code_out, ready, busy, tx_ok, tx_fail, attempt
  );

  modport slave (
    input  start, code_word, abort, ack_in,
    output code_out, ready, busy, tx_ok, tx_fail, attempt
  );
endinterface

// File: rtl/phase1_code_tx.sv
// Phase-1 serial unlock transmitter: shifts a latched code word out MSB first, then waits for
// the detector's done flag and resends on timeout until the retry budget is spent.
module phase1_code_tx #(
  parameter int unsigned CODE_WIDTH  = 4,
  parameter int unsigned BIT_CYCLES  = 1,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned ACK_TIMEOUT = 8,
  parameter int unsigned MAX_RETRIES = 2
) (
  input  logic              clk,
  input  logic              reset,
  phase1_code_tx_if.slave   bus
);
  localparam int unsigned ATT_W = $clog2(MAX_RETRIES + 2);
  localparam int unsigned BW    = (CODE_WIDTH  > 1) ? $clog2(CODE_WIDTH)  : 1;
  localparam int unsigned HW    = (BIT_CYCLES  > 1) ? $clog2(BIT_CYCLES)  : 1;
  localparam int unsigned GW    = (GAP_CYCLES  > 1) ? $clog2(GAP_CYCLES)  : 1;
  localparam int unsigned TW    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP, WAIT_ACK} state_t;

  state_t                state_q, state_d;
  logic [CODE_WIDTH-1:0] word_q,  word_d;
  logic [BW-1:0]         bit_q,   bit_d;
  logic [HW-1:0]         hold_q,  hold_d;
  logic [GW-1:0]         gap_q,   gap_d;
  logic [TW-1:0]         to_q,    to_d;
  logic [ATT_W-1:0]      att_q,   att_d;
  logic                  code_q,  code_d;
  logic                  ok_q,    ok_d;
  logic                  fail_q,  fail_d;
  logic                  ready_q, ready_d;
  logic                  busy_q,  busy_d;

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      bit_q   <= '0;
      hold_q  <= '0;
      gap_q   <= '0;
      to_q    <= '0;
      att_q   <= '0;
      code_q  <= 1'b0;
      ok_q    <= 1'b0;
      fail_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      bit_q   <= bit_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      to_q    <= to_d;
      att_q   <= att_d;
      code_q  <= code_d;
      ok_q    <= ok_d;
      fail_q  <= fail_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    bit_d   = bit_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    to_d    = to_q;
    att_d   = att_q;
    code_d  = 1'b0;
    ok_d    = 1'b0;
    fail_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          word_d  = bus.code_word;
          att_d   = '0;
          bit_d   = BW'(CODE_WIDTH - 1);
          hold_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        code_d = word_q[bit_q];
        if (hold_q == HW'(BIT_CYCLES - 1)) begin
          hold_d = '0;
          if (bit_q == '0) begin
            gap_d   = '0;
            to_d    = '0;
            state_d = (GAP_CYCLES > 0) ? GAP : WAIT_ACK;
          end else begin
            bit_d = bit_q - BW'(1);
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          to_d    = '0;
          state_d = WAIT_ACK;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      WAIT_ACK: begin
        // Ack takes priority over the timeout decision on the same cycle
        if (bus.ack_in) begin
          ok_d    = 1'b1;
          state_d = IDLE;
        end else if (to_q == TW'(ACK_TIMEOUT - 1)) begin
          if (att_q < ATT_W'(MAX_RETRIES)) begin
            att_d   = att_q + ATT_W'(1);
            bit_d   = BW'(CODE_WIDTH - 1);
            hold_d  = '0;
            state_d = SEND;
          end else begin
            fail_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.abort && (state_q != IDLE)) begin
      state_d = IDLE;
      att_d   = '0;
      code_d  = 1'b0;
      ok_d    = 1'b0;
      fail_d  = 1'b0;
    end
  end

  assign ready_d = (state_d == IDLE);
  assign busy_d  = (state_d != IDLE);

  assign bus.code_out = code_q;
  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;
  assign bus.tx_ok    = ok_q;
  assign bus.tx_fail  = fail_q;
  assign bus.attempt  = att_q;
endmodule

// File: tb/tb_phase1_code_tx.sv
// Scoreboard bench for phase1_code_tx: each transaction pushes its expected per-cycle output
// trace, and a negedge monitor pops and compares against the DUT.
module tb_phase1_code_tx;
  localparam int unsigned CW  = 4;
  localparam int unsigned G   = 2;
  localparam int unsigned TO  = 8;
  localparam int unsigned MR  = 2;

  typedef struct packed {
    logic       code;
    logic       rdy;
    logic       ok;
    logic       fail;
    logic [1:0] att;
  } item_t;

  logic clk;
  logic reset;
  int   err_cnt;
  int   chk_cnt;

  item_t trace[$];
  item_t exp_a[$];
  item_t exp_b[$];

  phase1_code_tx_if #(.CODE_WIDTH(CW), .MAX_RETRIES(MR)) bus_a ();
  phase1_code_tx_if #(.CODE_WIDTH(CW), .MAX_RETRIES(MR)) bus_b ();

  phase1_code_tx #(.CODE_WIDTH(CW), .BIT_CYCLES(1), .GAP_CYCLES(G),
                   .ACK_TIMEOUT(TO), .MAX_RETRIES(MR))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));

  phase1_code_tx #(.CODE_WIDTH(CW), .BIT_CYCLES(3), .GAP_CYCLES(G),
                   .ACK_TIMEOUT(TO), .MAX_RETRIES(MR))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    chk_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic item_t mk(input logic c, input logic r, input logic o, input logic f,
                               input int a);
    item_t it;
    it.code = c; it.rdy = r; it.ok = o; it.fail = f; it.att = 2'(a);
    return it;
  endfunction

  // Expected trace from the accept edge onward; cut_s ends the transfer (abort/reset) at that state cycle
  task automatic build(input int bc, input logic [3:0] word, input int ack_f, input int ack_t,
                       input int cut_s);
    int s;
    trace.delete();
    trace.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 0));
    s = 0;
    for (int f = 0; f <= int'(MR); f++) begin
      for (int b = CW - 1; b >= 0; b--) begin
        for (int h = 0; h < bc; h++) begin
          if (s == cut_s) begin
            trace.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 0));
            trace.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 0));
            return;
          end
          trace.push_back(mk(word[b], 1'b0, 1'b0, 1'b0, f));
          s++;
        end
      end
      for (int g = 0; g < int'(G); g++) begin
        trace.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, f));
        s++;
      end
      for (int t = 0; t < int'(TO); t++) begin
        if (f == ack_f && t == ack_t) begin
          trace.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, f));
          trace.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, f));
          return;
        end
        if (t == int'(TO) - 1) begin
          if (f < int'(MR)) trace.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, f + 1));
          else begin
            trace.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, f));
            trace.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, f));
            return;
          end
        end else begin
          trace.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, f));
        end
        s++;
      end
    end
  endtask

  // One transaction on DUT A; the *_s arguments are state-cycle indices (-1 = unused)
  task automatic run_a(input logic [3:0] word, input int ack_f, input int ack_t,
                       input int abort_s, input int rst_s, input int restart_s, input int spur_s);
    int ack_s;
    int cut_s;
    ack_s = (ack_f < 0) ? -1 : ack_f * int'(CW + G + TO) + int'(CW + G) + ack_t;
    cut_s = (abort_s >= 0) ? abort_s : rst_s;
    @(negedge clk);
    bus_a.code_word = word;
    bus_a.start     = 1'b1;
    @(posedge clk);
    #1;
    bus_a.start = 1'b0;
    build(1, word, ack_f, ack_t, cut_s);
    foreach (trace[i]) exp_a.push_back(trace[i]);
    for (int s = 0; s < 400 && exp_a.size() > 0; s++) begin
      bus_a.ack_in = (s == ack_s) || (s == spur_s);
      bus_a.abort  = (s == abort_s);
      reset        = (s == rst_s);
      if (s == restart_s) begin
        bus_a.code_word = 4'b0000;
        bus_a.start     = 1'b1;
      end else begin
        bus_a.start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    bus_a.ack_in = 1'b0;
    bus_a.abort  = 1'b0;
    bus_a.start  = 1'b0;
    reset        = 1'b0;
    check_val("drain_a", 32'(exp_a.size()), 32'd0);
    exp_a.delete();
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    item_t e;
    if (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      check_val("a_code",  32'(bus_a.code_out), 32'(e.code));
      check_val("a_ready", 32'(bus_a.ready),    32'(e.rdy));
      check_val("a_busy",  32'(bus_a.busy),     32'(!e.rdy));
      check_val("a_ok",    32'(bus_a.tx_ok),    32'(e.ok));
      check_val("a_fail",  32'(bus_a.tx_fail),  32'(e.fail));
      check_val("a_att",   32'(bus_a.attempt),  32'(e.att));
    end
  end

  always @(negedge clk) begin
    item_t e;
    if (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      check_val("b_code",  32'(bus_b.code_out), 32'(e.code));
      check_val("b_ready", 32'(bus_b.ready),    32'(e.rdy));
      check_val("b_ok",    32'(bus_b.tx_ok),    32'(e.ok));
      check_val("b_fail",  32'(bus_b.tx_fail),  32'(e.fail));
      check_val("b_att",   32'(bus_b.attempt),  32'(e.att));
    end
  end

  initial begin
    err_cnt = 0;
    chk_cnt = 0;
    reset = 1'b1;
    bus_a.start = 1'b0; bus_a.code_word = '0; bus_a.abort = 1'b0; bus_a.ack_in = 1'b0;
    bus_b.start = 1'b0; bus_b.code_word = '0; bus_b.abort = 1'b0; bus_b.ack_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_code",  32'(bus_a.code_out), 32'd0);
    check_val("rst_ready", 32'(bus_a.ready),    32'd1);
    check_val("rst_busy",  32'(bus_a.busy),     32'd0);
    check_val("rst_ok",    32'(bus_a.tx_ok),    32'd0);
    check_val("rst_fail",  32'(bus_a.tx_fail),  32'd0);
    check_val("rst_att",   32'(bus_a.attempt),  32'd0);
    reset = 1'b0;

    // Basic frame, ack on the first wait cycle
    run_a(4'b1011, 0, 0, -1, -1, -1, -1);

    // Slow bit timing on DUT B: ack on its first wait cycle
    @(negedge clk);
    bus_b.code_word = 4'b1011;
    bus_b.start     = 1'b1;
    @(posedge clk);
    #1;
    bus_b.start = 1'b0;
    build(3, 4'b1011, 0, 0, -1);
    foreach (trace[i]) exp_b.push_back(trace[i]);
    for (int s = 0; s < 400 && exp_b.size() > 0; s++) begin
      bus_b.ack_in = (s == int'(CW * 3 + G));
      @(posedge clk);
      #1;
    end
    bus_b.ack_in = 1'b0;
    check_val("drain_b", 32'(exp_b.size()), 32'd0);
    exp_b.delete();

    // No ack: three frames then tx_fail; an ack during SEND must be ignored
    run_a(4'b1011, -1, 0, -1, -1, -1, 2);
    // Abort during bit 2, then a new start straight away
    run_a(4'b1011, -1, 0, 1, -1, -1, -1);
    run_a(4'b0110, 0, 2, -1, -1, -1, -1);
    // Start re-pulsed while busy with 0000; ack on the final timeout cycle
    run_a(4'b1011, 0, int'(TO) - 1, -1, -1, 1, -1);
    // Ack on a retry frame
    run_a(4'b1101, 1, 3, -1, -1, -1, -1);
    // Reset mid-SEND, then stays idle
    run_a(4'b1011, -1, 0, -1, 2, -1, -1);
    repeat (2) exp_a.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 0));
    repeat (3) @(posedge clk);

    // Start together with abort in IDLE is ignored
    @(negedge clk);
    bus_a.code_word = 4'b1111;
    bus_a.start = 1'b1;
    bus_a.abort = 1'b1;
    @(posedge clk);
    #1;
    bus_a.start = 1'b0;
    bus_a.abort = 1'b0;
    repeat (3) exp_a.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 0));
    repeat (4) @(posedge clk);
    check_val("drain_idle", 32'(exp_a.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
